// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register completer.
// Offsets, FSM states, captured request bundle and byte parity helper.
package apb_reg_pkg;

   localparam logic [7:0]  OFF_ID      = 8'h00;
   localparam logic [7:0]  OFF_SCRATCH = 8'h04;
   localparam logic [7:0]  OFF_CTRL    = 8'h08;
   localparam logic [7:0]  OFF_STATUS  = 8'h0C;
   localparam logic [7:0]  OFF_ERRCNT  = 8'h10;

   localparam logic [31:0] ID_DEFAULT  = 32'hEF1A_0001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic [7:0]  off;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        err;
      logic        par;
   } req_t;

   function automatic logic [3:0] odd_par32(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) begin
         p[i] = ~^d[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/apb_byte_parity.sv
// Per-byte odd parity generator with a strobe-masked mismatch vector.
// Used for both write-data checking and read-data generation.
module apb_byte_parity
   import apb_reg_pkg::*;
(
   input  logic [31:0] data,
   input  logic [3:0]  par,
   input  logic [3:0]  mask,
   output logic [3:0]  gen,
   output logic [3:0]  mis
);

   assign gen = odd_par32(data);
   assign mis = (gen ^ par) & mask;

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with ID/scratch/ctrl/status/error-count registers,
// configurable wait states and byte parity on write and read data.
module apb_reg_completer
   import apb_reg_pkg::*;
#(
   parameter int          ADDR_W      = 24,
   parameter int          WAIT_STATES = 0,
   parameter bit          PAR_CHECK   = 1'b1,
   parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
   input  logic              apbclk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   input  logic [3:0]        PWDATA_PAR,
   input  logic [3:0]        PSTRB,
   input  logic              PSTRB_PAR,
   output logic [31:0]       PRDATA,
   output logic [3:0]        PRDATA_PAR,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [7:0]        ctrl_o,
   input  logic [31:0]       status_i,
   output logic              par_err_o
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept, to_resp;
   req_t        req_in, req_q, req_cur;
   logic [31:0] status_q, status_cur;
   logic [31:0] scratch_q;
   logic [7:0]  ctrl_q;
   logic [15:0] errcnt_q;
   logic [31:0] rd_val, rdata_d;
   logic [3:0]  rd_par, w_mis;
   logic [3:0]  w_gen_unused, rd_mis_unused;
   logic        strb_par_bad, par_bad;
   logic        hi_err, map_err, ro_err;
   logic [7:0]  off;
   logic        addr_unused;

   assign addr_unused = ^PADDR[1:0];
   assign off         = {PADDR[7:2], 2'b00};
   assign hi_err      = (PADDR >> 8) != '0;

   apb_byte_parity u_wpar (
      .data (PWDATA),
      .par  (PWDATA_PAR),
      .mask (PSTRB),
      .gen  (w_gen_unused),
      .mis  (w_mis)
   );

   assign strb_par_bad = PSTRB_PAR != ~^PSTRB;
   assign par_bad      = PWRITE & ((|w_mis) | strb_par_bad);

   always_comb begin
      map_err = 1'b0;
      ro_err  = 1'b0;
      unique case (off)
         OFF_ID, OFF_STATUS: ro_err = PWRITE;
         OFF_SCRATCH, OFF_CTRL, OFF_ERRCNT: ;
         default: map_err = 1'b1;
      endcase
   end

   always_comb begin
      req_in.off   = off;
      req_in.wr    = PWRITE;
      req_in.wdata = PWDATA;
      req_in.strb  = PSTRB;
      req_in.err   = hi_err | map_err | ro_err | (PAR_CHECK & par_bad);
      req_in.par   = par_bad;
   end

   // With no wait states the response is built from the live setup inputs
   assign req_cur    = (state_q == IDLE) ? req_in : req_q;
   assign status_cur = (state_q == IDLE) ? status_i : status_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      to_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               accept = 1'b1;
               cnt_d  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  state_d = RESP;
                  to_resp = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (PENABLE) begin
               if (cnt_q == 4'd1) begin
                  state_d = RESP;
                  to_resp = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge apbclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge apbclk or posedge rst) begin
      if (rst) begin
         req_q    <= '0;
         status_q <= '0;
      end else if (accept) begin
         req_q    <= req_in;
         status_q <= status_i;
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (req_cur.off)
         OFF_ID:      rd_val = ID_VALUE;
         OFF_SCRATCH: rd_val = scratch_q;
         OFF_CTRL:    rd_val = {24'h0, ctrl_q};
         OFF_STATUS:  rd_val = status_cur;
         OFF_ERRCNT:  rd_val = {16'h0, errcnt_q};
         default:     rd_val = '0;
      endcase
      rdata_d = (req_cur.err | req_cur.wr) ? '0 : rd_val;
   end

   apb_byte_parity u_rpar (
      .data (rdata_d),
      .par  (4'h0),
      .mask (4'h0),
      .gen  (rd_par),
      .mis  (rd_mis_unused)
   );

   always_ff @(posedge apbclk or posedge rst) begin
      if (rst) begin
         PREADY     <= 1'b0;
         PSLVERR    <= 1'b0;
         PRDATA     <= '0;
         PRDATA_PAR <= 4'hF;
         par_err_o  <= 1'b0;
      end else begin
         par_err_o <= (state_q == RESP) & req_q.par;
         if (to_resp) begin
            PREADY     <= 1'b1;
            PSLVERR    <= req_cur.err;
            PRDATA     <= rdata_d;
            PRDATA_PAR <= rd_par;
         end else if (state_q == RESP) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
         end
      end
   end

   // Commit and error accounting happen on the edge closing the PREADY cycle
   always_ff @(posedge apbclk or posedge rst) begin
      if (rst) begin
         scratch_q <= '0;
         ctrl_q    <= '0;
         errcnt_q  <= '0;
      end else if (state_q == RESP) begin
         if (req_q.err) begin
            if (errcnt_q != 16'hFFFF) begin
               errcnt_q <= errcnt_q + 16'd1;
            end
         end else if (req_q.wr) begin
            if (req_q.off == OFF_SCRATCH) begin
               for (int i = 0; i < 4; i++) begin
                  if (req_q.strb[i]) begin
                     scratch_q[8*i +: 8] <= req_q.wdata[8*i +: 8];
                  end
               end
            end
            if (req_q.off == OFF_CTRL && req_q.strb[0]) begin
               ctrl_q <= req_q.wdata[7:0];
            end
            if (req_q.off == OFF_ERRCNT && |req_q.strb) begin
               errcnt_q <= '0;
            end
         end
      end
   end

   assign ctrl_o = ctrl_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: zero-wait and three-wait instances,
// directed table, corner sequences and randomized model comparison.
module tb_apb_reg_completer;

   logic        apbclk = 1'b0;
   logic        rst    = 1'b1;
   logic [23:0] PADDR  = '0;
   logic        PSEL   = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PWDATA = '0;
   logic [3:0]  PWDATA_PAR = '0;
   logic [3:0]  PSTRB  = '0;
   logic        PSTRB_PAR = 1'b0;
   logic [31:0] status_i = '0;
   bit          use3 = 1'b0;

   logic [31:0] prdata0, prdata1;
   logic [3:0]  prpar0, prpar1;
   logic        pready0, pready1, pslverr0, pslverr1;
   logic        perr0, perr1;
   logic [7:0]  ctrl0, ctrl1;
   logic        psel0, psel1;

   logic [31:0] r_prdata;
   logic [3:0]  r_prpar;
   logic        r_pready, r_pslverr, r_perr;
   logic [7:0]  r_ctrl;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_scr [2];
   logic [7:0]  m_ctrl [2];
   logic [15:0] m_err [2];

   always #5 apbclk = ~apbclk;

   assign psel0 = PSEL & ~use3;
   assign psel1 = PSEL & use3;

   assign r_prdata  = use3 ? prdata1  : prdata0;
   assign r_prpar   = use3 ? prpar1   : prpar0;
   assign r_pready  = use3 ? pready1  : pready0;
   assign r_pslverr = use3 ? pslverr1 : pslverr0;
   assign r_perr    = use3 ? perr1    : perr0;
   assign r_ctrl    = use3 ? ctrl1    : ctrl0;

   apb_reg_completer #(.WAIT_STATES(0)) dut0 (
      .apbclk(apbclk), .rst(rst), .PADDR(PADDR), .PSEL(psel0),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PWDATA_PAR(PWDATA_PAR), .PSTRB(PSTRB), .PSTRB_PAR(PSTRB_PAR),
      .PRDATA(prdata0), .PRDATA_PAR(prpar0), .PREADY(pready0),
      .PSLVERR(pslverr0), .ctrl_o(ctrl0), .status_i(status_i),
      .par_err_o(perr0)
   );

   apb_reg_completer #(.WAIT_STATES(3)) dut3 (
      .apbclk(apbclk), .rst(rst), .PADDR(PADDR), .PSEL(psel1),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PWDATA_PAR(PWDATA_PAR), .PSTRB(PSTRB), .PSTRB_PAR(PSTRB_PAR),
      .PRDATA(prdata1), .PRDATA_PAR(prpar1), .PREADY(pready1),
      .PSLVERR(pslverr1), .ctrl_o(ctrl1), .status_i(status_i),
      .par_err_o(perr1)
   );

   function automatic logic [3:0] bpar(input logic [31:0] d);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i] = ($countones(d[8*i +: 8]) % 2) == 0;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_scr[i]  = '0;
         m_ctrl[i] = '0;
         m_err[i]  = '0;
      end
   endtask

   task automatic xfer(input logic [23:0] a, input bit wr,
                       input logic [31:0] wd, input logic [3:0] sb,
                       input logic [4:0] fl, output logic [31:0] rd,
                       output logic [3:0] rp, output bit err,
                       output bit pe, output int waits);
      @(posedge apbclk); #1;
      PADDR      = a;
      PWRITE     = wr;
      PWDATA     = wd;
      PSTRB      = sb;
      PWDATA_PAR = bpar(wd) ^ fl[3:0];
      PSTRB_PAR  = (($countones(sb) % 2) == 0) ^ fl[4];
      PSEL       = 1'b1;
      PENABLE    = 1'b0;
      @(posedge apbclk); #1;
      PENABLE  = 1'b1;
      status_i = $urandom;
      waits    = 0;
      while (!r_pready && waits < 40) begin
         @(posedge apbclk); #1;
         waits++;
      end
      if (!r_pready) begin
         checks++;
         failures++;
         $display("FAIL pready_timeout addr=%h got=0 exp=1", a);
      end
      rd  = r_prdata;
      rp  = r_prpar;
      err = r_pslverr;
      @(posedge apbclk); #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      pe      = r_perr;
      chk("pready_one_cycle", {31'h0, r_pready}, 32'h0);
   endtask

   task automatic do_x(input logic [23:0] a, input bit wr,
                       input logic [31:0] wd, input logic [3:0] sb,
                       input logic [4:0] fl, input logic [31:0] st,
                       output logic [31:0] rd, output bit err,
                       output bit pe);
      int          d, waits;
      int          idx;
      bit          bad, e_err, e_pe;
      logic [31:0] e_rd, v;
      logic [3:0]  rp;
      d   = use3 ? 1 : 0;
      idx = int'(a[7:2]);
      bad = fl[4] || ((fl[3:0] & sb) != 4'h0);
      e_err = (a[23:8] != 16'h0) || (idx > 4) ||
              (wr && (idx == 0 || idx == 3)) || (wr && bad);
      e_pe = wr && bad;
      case (idx)
         0:       v = 32'hEF1A_0001;
         1:       v = m_scr[d];
         2:       v = {24'h0, m_ctrl[d]};
         3:       v = st;
         4:       v = {16'h0, m_err[d]};
         default: v = '0;
      endcase
      e_rd = (e_err || wr) ? 32'h0 : v;
      if (e_err) begin
         if (m_err[d] != 16'hFFFF) m_err[d] = m_err[d] + 16'd1;
      end else if (wr) begin
         if (idx == 1) begin
            for (int i = 0; i < 4; i++) begin
               if (sb[i]) m_scr[d][8*i +: 8] = wd[8*i +: 8];
            end
         end
         if (idx == 2 && sb[0]) m_ctrl[d] = wd[7:0];
         if (idx == 4 && sb != 4'h0) m_err[d] = '0;
      end
      status_i = st;
      xfer(a, wr, wd, sb, fl, rd, rp, err, pe, waits);
      chk("prdata", rd, e_rd);
      chk("prdata_par", {28'h0, rp}, {28'h0, bpar(e_rd)});
      chk("pslverr", {31'h0, err}, {31'h0, e_err});
      chk("par_err_pulse", {31'h0, pe}, {31'h0, e_pe});
      chk("wait_cycles", waits, use3 ? 3 : 0);
      chk("ctrl_o", {24'h0, r_ctrl}, {24'h0, m_ctrl[d]});
   endtask

   typedef struct {
      logic [23:0] a;
      bit          wr;
      logic [31:0] wd;
      logic [3:0]  sb;
      logic [4:0]  fl;
      logic [31:0] ex_rd;
      bit          ex_err;
      bit          ex_pe;
   } vec_t;

   vec_t tbl [19];

   initial begin
      logic [31:0] rd;
      bit          err, pe, seen;
      logic [23:0] addrs [8];

      tbl[0]  = '{24'h00, 1'b0, 32'h0, 4'h0, 5'h00, 32'hEF1A_0001, 1'b0, 1'b0};
      tbl[1]  = '{24'h04, 1'b1, 32'hA5A5_1234, 4'b0101, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[2]  = '{24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h00A5_0034, 1'b0, 1'b0};
      tbl[3]  = '{24'h08, 1'b1, 32'h5A, 4'b0001, 5'h01, 32'h0, 1'b1, 1'b1};
      tbl[4]  = '{24'h08, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[5]  = '{24'h10, 1'b0, 32'h0, 4'h0, 5'h00, 32'h1, 1'b0, 1'b0};
      tbl[6]  = '{24'h20, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, 1'b1, 1'b0};
      tbl[7]  = '{24'h00, 1'b1, 32'h1, 4'hF, 5'h00, 32'h0, 1'b1, 1'b0};
      tbl[8]  = '{24'h10, 1'b0, 32'h0, 4'h0, 5'h00, 32'h3, 1'b0, 1'b0};
      tbl[9]  = '{24'h10, 1'b1, 32'h0, 4'b0001, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[10] = '{24'h10, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[11] = '{24'h08, 1'b1, 32'h5A, 4'b0001, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[12] = '{24'h08, 1'b0, 32'h0, 4'h0, 5'h00, 32'h5A, 1'b0, 1'b0};
      tbl[13] = '{24'h04, 1'b1, 32'hFFFF_FFFF, 4'h0, 5'h00, 32'h0, 1'b0, 1'b0};
      tbl[14] = '{24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h00A5_0034, 1'b0, 1'b0};
      tbl[15] = '{24'h0C, 1'b0, 32'h0, 4'h0, 5'h00, 32'hDEAD_BEEF, 1'b0, 1'b0};
      tbl[16] = '{24'h104, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, 1'b1, 1'b0};
      tbl[17] = '{24'h04, 1'b1, 32'h7777_7777, 4'b0011, 5'h10, 32'h0, 1'b1, 1'b1};
      tbl[18] = '{24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h00A5_0034, 1'b0, 1'b0};

      addrs = '{24'h00, 24'h04, 24'h08, 24'h0C, 24'h10, 24'h14,
                24'h20, 24'h104};

      model_reset();
      #12;
      for (int k = 0; k < 2; k++) begin
         use3 = (k == 1);
         #1;
         chk("rst_prdata", r_prdata, 32'h0);
         chk("rst_prdata_par", {28'h0, r_prpar}, 32'hF);
         chk("rst_pready", {31'h0, r_pready}, 32'h0);
         chk("rst_pslverr", {31'h0, r_pslverr}, 32'h0);
         chk("rst_par_err", {31'h0, r_perr}, 32'h0);
         chk("rst_ctrl", {24'h0, r_ctrl}, 32'h0);
      end
      #8 rst = 1'b0;

      use3 = 1'b0;
      for (int i = 0; i < 19; i++) begin
         do_x(tbl[i].a, tbl[i].wr, tbl[i].wd, tbl[i].sb, tbl[i].fl,
              32'hDEAD_BEEF, rd, err, pe);
         chk($sformatf("tbl%0d_rd", i), rd, tbl[i].ex_rd);
         chk($sformatf("tbl%0d_err", i), {31'h0, err}, {31'h0, tbl[i].ex_err});
         chk($sformatf("tbl%0d_pe", i), {31'h0, pe}, {31'h0, tbl[i].ex_pe});
      end

      // access phase without setup must be ignored
      @(posedge apbclk); #1;
      PADDR = 24'h0; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(posedge apbclk); #1;
         seen |= r_pready;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("idle_access_ignored", {31'h0, seen}, 32'h0);

      // three wait states: status read with capture at setup
      use3 = 1'b1;
      do_x(24'h0C, 1'b0, 32'h0, 4'h0, 5'h00, 32'hDEAD_BEEF, rd, err, pe);
      chk("ws3_status", rd, 32'hDEAD_BEEF);

      // abort after one wait cycle
      @(posedge apbclk); #1;
      PADDR = 24'h04; PWRITE = 1'b1; PWDATA = 32'h1234_5678;
      PSTRB = 4'hF; PWDATA_PAR = bpar(32'h1234_5678); PSTRB_PAR = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge apbclk); #1;
      PENABLE = 1'b1;
      chk("abort_wait_low", {31'h0, r_pready}, 32'h0);
      @(posedge apbclk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge apbclk); #1;
         seen |= r_pready | r_perr;
      end
      chk("abort_no_ready", {31'h0, seen}, 32'h0);
      do_x(24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, rd, err, pe);
      do_x(24'h10, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, rd, err, pe);

      // reset while PREADY is high on the zero-wait instance
      use3 = 1'b0;
      @(posedge apbclk); #1;
      PADDR = 24'h04; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF;
      PSTRB = 4'hF; PWDATA_PAR = bpar(32'hFFFF_FFFF); PSTRB_PAR = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge apbclk); #1;
      PENABLE = 1'b1;
      chk("rst_resp_ready_hi", {31'h0, r_pready}, 32'h1);
      #2 rst = 1'b1;
      #1 chk("rst_resp_ready_clr", {31'h0, r_pready}, 32'h0);
      @(posedge apbclk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; rst = 1'b0;
      model_reset();
      do_x(24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, rd, err, pe);
      chk("rst_resp_scratch", rd, 32'h0);

      // reset during the wait phase of the three-wait instance
      use3 = 1'b1;
      @(posedge apbclk); #1;
      PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge apbclk); #1;
      PENABLE = 1'b1;
      @(posedge apbclk); #1;
      rst = 1'b1;
      #1 chk("rst_wait_ready", {31'h0, r_pready}, 32'h0);
      @(posedge apbclk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; rst = 1'b0;
      model_reset();
      do_x(24'h04, 1'b0, 32'h0, 4'h0, 5'h00, 32'h0, rd, err, pe);
      chk("rst_wait_scratch", rd, 32'h0);

      for (int n = 0; n < 200; n++) begin
         logic [4:0] fl;
         use3 = $urandom_range(0, 1) == 1;
         fl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
         do_x(addrs[$urandom_range(0, 7)], $urandom_range(0, 1) == 1,
              $urandom, 4'($urandom), fl, $urandom, rd, err, pe);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
